// File: rtl/if_stage.sv
// Instruction-fetch stage: assembles 32-bit little-endian instructions from a byte-wide
// memory port and presents {pc_o, inst_o} to decode through a single stallable output slot.
module if_stage #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  stall,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [7:0]            mem_data,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  inst_valid
);

    typedef enum logic [0:0] {StFetch, StWait} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [INST_WIDTH-1:0]   buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic                    valid_q, valid_d;

    logic                    slot_free;
    logic                    load;
    logic [INST_WIDTH-1:0]   load_inst;
    logic [ADDR_WIDTH-1:0]   jump_target;

    // Redirect targets are word aligned; the low address bits carry no information.
    logic unused_jump_lsb;
    assign unused_jump_lsb = ^jump_addr[1:0];
    assign jump_target     = {jump_addr[ADDR_WIDTH-1:2], 2'b00};

    assign slot_free  = !valid_q || !stall;

    assign mem_req    = rst && rdy && (state_q == StFetch);
    assign mem_addr   = fetch_pc_q + {{(ADDR_WIDTH-2){1'b0}}, byte_cnt_q};
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign inst_valid = valid_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        load       = 1'b0;
        load_inst  = buf_q;

        if (rdy) begin
            if (jump_en) begin
                fetch_pc_d = jump_target;
                byte_cnt_d = 2'd0;
                valid_d    = 1'b0;
                state_d    = StFetch;
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (mem_valid) begin
                            buf_d[8*byte_cnt_q +: 8] = mem_data;
                            byte_cnt_d               = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                // Last byte bypasses the buffer so a free slot loads this edge.
                                if (slot_free) begin
                                    load      = 1'b1;
                                    load_inst = {mem_data, buf_q[23:0]};
                                end else begin
                                    state_d = StWait;
                                end
                            end
                        end
                    end
                    StWait: begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_inst = buf_q;
                            state_d   = StFetch;
                        end
                    end
                    default: state_d = StFetch;
                endcase

                if (load) begin
                    pc_d       = fetch_pc_q;
                    inst_d     = load_inst;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                end else if (valid_q && !stall) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            byte_cnt_q <= 2'd0;
            buf_q      <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against an
// instruction-stream model (consumed instructions must follow sequentially from the last redirect).
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_data;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid;

    int checks;
    int failures;

    if_stage #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .stall     (stall),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .pc_o      (pc_o),
        .inst_o    (inst_o),
        .inst_valid(inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] r;
        case (a)
            32'h0:   r = 8'h13;
            32'h1:   r = 8'h05;
            32'h2:   r = 8'h10;
            32'h3:   r = 8'h00;
            default: r = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    assign mem_data = mem_byte(mem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0; mem_valid = 1'b1;
        #12;
        checks++;
        if (pc_o !== 32'h0 || inst_o !== 32'h0 || inst_valid !== 1'b0 || mem_req !== 1'b0
            || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: pc=%h inst=%h v=%b req=%b addr=%h, need all zero",
                     pc_o, inst_o, inst_valid, mem_req, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h, need 1/0", mem_req, mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                checks++;
                if (mem_addr !== 32'(i) || inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL first_fetch_addr: addr=%h v=%b, need %h/0", mem_addr, inst_valid, i);
                end
            end
        end
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00100513 || mem_addr !== 32'h4) begin
            failures++;
            $display("FAIL first_inst: v=%b pc=%h inst=%h addr=%h, need 1/0/00100513/4",
                     inst_valid, pc_o, inst_o, mem_addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00100513) begin
            failures++;
            $display("FAIL stall_hold: req=%b v=%b pc=%h inst=%h, need 0/1/0/00100513",
                     mem_req, inst_valid, pc_o, inst_o);
        end
        stall = 1'b0;
        step();
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h4 || inst_o !== word_at(32'h4) || mem_addr !== 32'h8
            || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: v=%b pc=%h inst=%h addr=%h req=%b, need 1/4/%h/8/1",
                     inst_valid, pc_o, inst_o, mem_addr, mem_req, word_at(32'h4));
        end
    endtask

    task automatic test_jump();
        step();
        step();
        checks++;
        if (mem_addr !== 32'ha) begin
            failures++;
            $display("FAIL jump_setup: addr=%h, need 0000000a", mem_addr);
        end
        jump_en = 1'b1; jump_addr = 32'h1003;
        step();
        jump_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_addr !== 32'h1000) begin
            failures++;
            $display("FAIL jump_redirect: v=%b addr=%h, need 0/00001000", inst_valid, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL jump_bubble: v=%b pc=%h at cycle %0d, need 0", inst_valid, pc_o, i);
                end
            end
        end
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h1000 || inst_o !== word_at(32'h1000)) begin
            failures++;
            $display("FAIL jump_target_inst: v=%b pc=%h inst=%h, need 1/00001000/%h",
                     inst_valid, pc_o, inst_o, word_at(32'h1000));
        end
    endtask

    task automatic test_sparse_valid();
        for (int k = 0; k < 12; k++) begin
            mem_valid = (k % 3 == 2);
            step();
            if (k < 11) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL sparse_early: v=%b at cycle %0d, need 0", inst_valid, k);
                end
            end
        end
        mem_valid = 1'b1;
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h1004 || inst_o !== word_at(32'h1004)) begin
            failures++;
            $display("FAIL sparse_inst: v=%b pc=%h inst=%h, need 1/00001004/%h",
                     inst_valid, pc_o, inst_o, word_at(32'h1004));
        end
    endtask

    task automatic test_rdy_freeze();
        step();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b0 || mem_addr !== 32'h100a) begin
                failures++;
                $display("FAIL rdy_freeze: req=%b addr=%h, need 0/0000100a", mem_req, mem_addr);
            end
        end
        rdy = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100a) begin
            failures++;
            $display("FAIL rdy_resume: req=%b addr=%h, need 1/0000100a", mem_req, mem_addr);
        end
        step();
        step();
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h1008 || inst_o !== word_at(32'h1008)) begin
            failures++;
            $display("FAIL rdy_inst: v=%b pc=%h inst=%h, need 1/00001008/%h",
                     inst_valid, pc_o, inst_o, word_at(32'h1008));
        end
    endtask

    task automatic test_reset_mid_fetch();
        jump_en = 1'b1; jump_addr = 32'h40;
        step();
        jump_en = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h0 || inst_o !== 32'h0 || inst_valid !== 1'b0 || mem_req !== 1'b0
            || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: pc=%h inst=%h v=%b req=%b addr=%h, need all zero",
                     pc_o, inst_o, inst_valid, mem_req, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (mem_addr !== 32'h1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart: addr=%h v=%b, need 1/0", mem_addr, inst_valid);
        end
    endtask

    // Model: each consumed instruction is the next word after the previous one, restarting at a
    // redirect target; a presented instruction must always be that next expected word.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        logic        pre_valid;
        exp_pc   = 32'h1;
        consumed = 0;
        // Align the model with the DUT via a redirect near the top of the address space.
        jump_en = 1'b1; jump_addr = 32'hFFFFFFF8; rdy = 1'b1; stall = 1'b0; mem_valid = 1'b1;
        step();
        exp_pc  = 32'hFFFFFFF8;
        jump_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rdy       = ($urandom_range(7) != 0);
            stall     = ($urandom_range(2) == 0);
            mem_valid = ($urandom_range(1) == 0);
            jump_en   = ($urandom_range(49) == 0);
            jump_addr = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | $urandom_range(15)) : $urandom;
            pre_valid = inst_valid;
            #1;
            if (!rdy) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_req_rdy: req=%b with rdy=0, need 0", mem_req);
                end
            end
            step();
            if (rdy && jump_en) begin
                exp_pc = {jump_addr[31:2], 2'b00};
            end else if (rdy && pre_valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (pc_o !== exp_pc || inst_o !== word_at(exp_pc)) begin
                    failures++;
                    $display("FAIL rand_stream: pc=%h inst=%h, need %h/%h", pc_o, inst_o, exp_pc,
                             word_at(exp_pc));
                end
            end
        end
        jump_en = 1'b0;
        checks++;
        if (consumed < 50) begin
            failures++;
            $display("FAIL rand_progress: consumed=%0d, need >= 50", consumed);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_jump();
        test_sparse_valid();
        test_rdy_freeze();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
